multi_channel_mac_accumulator: RTL and testbench

//  Parametrised successor of the hidden/output-layer weighted-sum block. Computes NCH neuron sums in

---
 rtl/multi_channel_mac_accumulator.sv | 159 +++++++++++++++
 tb/tb_multi_channel_mac_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_mac_accumulator.sv
// Multi-lane signed multiply-accumulate with bias add, requantisation shift, optional ReLU
// and output saturation; input beats use valid/ready, results are held until accepted.
module multi_channel_mac_accumulator #(
    parameter int NWBITS     = 16,
    parameter int NINBITS    = 26,
    parameter int NCH        = 10,
    parameter int NTERMS     = 256,
    parameter int COUNT_BITS = 8,
    parameter int OUT_SHIFT  = 8,
    parameter int OUT_BITS   = 16,
    parameter int RELU_EN    = 1
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NINBITS-1:0]        in_data,
    input  logic [NCH*NWBITS-1:0]     weight,
    input  logic [NCH*NWBITS-1:0]     bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH*OUT_BITS-1:0]   out_data,
    output logic                      busy
);

    localparam int PBITS    = NINBITS + NWBITS;
    localparam int ACC_BITS = PBITS + COUNT_BITS;
    // One guard bit so the bias add itself can never wrap before saturation.
    localparam int SUM_BITS = ACC_BITS + 1;
    localparam logic signed [SUM_BITS-1:0] OUT_MAX = SUM_BITS'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [SUM_BITS-1:0] OUT_MIN = -OUT_MAX - SUM_BITS'(64'sd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [COUNT_BITS-1:0]       count_r;
    logic signed [ACC_BITS-1:0]  acc_r [NCH];
    logic signed [PBITS-1:0]     prod_s [NCH];
    logic [NCH*OUT_BITS-1:0]     res_s;
    logic [NCH*OUT_BITS-1:0]     out_data_r;
    logic                        out_valid_r;
    logic                        in_ready_r;
    logic                        busy_r;
    logic                        beat_s;
    logic                        last_beat_s;

    function automatic logic [OUT_BITS-1:0] requant(
        input logic signed [ACC_BITS-1:0] acc,
        input logic signed [NWBITS-1:0]   b
    );
        logic signed [SUM_BITS-1:0] sum_v;
        logic signed [SUM_BITS-1:0] shr_v;
        logic [OUT_BITS-1:0]        res_v;
        sum_v = $signed({acc[ACC_BITS-1], acc}) + $signed({{(SUM_BITS-NWBITS){b[NWBITS-1]}}, b});
        shr_v = sum_v >>> OUT_SHIFT;
        if ((RELU_EN != 0) && (shr_v[SUM_BITS-1] == 1'b1)) begin
            shr_v = {SUM_BITS{1'b0}};
        end else begin
            shr_v = shr_v;
        end
        if (shr_v > OUT_MAX) begin
            res_v = OUT_MAX[OUT_BITS-1:0];
        end else if (shr_v < OUT_MIN) begin
            res_v = OUT_MIN[OUT_BITS-1:0];
        end else begin
            res_v = shr_v[OUT_BITS-1:0];
        end
        return res_v;
    endfunction

    assign beat_s      = (state_r == ACCUM) && in_valid;
    assign last_beat_s = beat_s && (count_r == COUNT_BITS'(NTERMS - 1));

    // Per-lane products and requantised results.
    always_comb begin
        res_s = {(NCH*OUT_BITS){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            prod_s[k] = $signed(in_data) * $signed(weight[k*NWBITS +: NWBITS]);
            res_s[k*OUT_BITS +: OUT_BITS] = requant(acc_r[k], bias[k*NWBITS +: NWBITS]);
        end
    end

    // Next-state decode; abort overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = start ? ACCUM : IDLE;
                ACCUM:   state_nxt_s = last_beat_s ? BIAS : ACCUM;
                BIAS:    state_nxt_s = HOLD;
                HOLD:    state_nxt_s = out_ready ? IDLE : HOLD;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, term counter and accumulators; aborted runs leave stale sums until the next start.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r <= IDLE;
            count_r <= {COUNT_BITS{1'b0}};
            for (int k = 0; k < NCH; k++) begin
                acc_r[k] <= {ACC_BITS{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            if (abort) begin
                count_r <= {COUNT_BITS{1'b0}};
            end else if ((state_r == IDLE) && start) begin
                count_r <= {COUNT_BITS{1'b0}};
                for (int k = 0; k < NCH; k++) begin
                    acc_r[k] <= {ACC_BITS{1'b0}};
                end
            end else if (beat_s) begin
                count_r <= last_beat_s ? {COUNT_BITS{1'b0}} : count_r + COUNT_BITS'(1);
                for (int k = 0; k < NCH; k++) begin
                    acc_r[k] <= acc_r[k] + $signed({{COUNT_BITS{prod_s[k][PBITS-1]}}, prod_s[k]});
                end
            end
        end
    end

    // Registered handshake/status outputs and result capture.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_data_r  <= {(NCH*OUT_BITS){1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ACCUM);
            busy_r     <= (state_nxt_s != IDLE);
            if (abort) begin
                out_valid_r <= 1'b0;
            end else if (state_r == BIAS) begin
                out_valid_r <= 1'b1;
                out_data_r  <= res_s;
            end else if ((state_r == HOLD) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_multi_channel_mac_accumulator.sv
// Directed bench: three 2-lane, 4-term instances (shift/ReLU variants) driven with shared stimulus.
module tb_multi_channel_mac_accumulator;

    logic        clk;
    logic        reset_b;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [25:0] in_data;
    logic [31:0] weight;
    logic [31:0] bias;
    logic        out_ready;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic        busy_a, busy_b, busy_c;

    int n_cmp;
    int n_err;

    // A: no shift, no ReLU
    multi_channel_mac_accumulator #(
        .NWBITS(16), .NINBITS(26), .NCH(2), .NTERMS(4), .COUNT_BITS(2),
        .OUT_SHIFT(0), .OUT_BITS(16), .RELU_EN(0)
    ) dut_a (
        .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .weight(weight), .bias(bias), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a)
    );

    // B: shift 4 with ReLU
    multi_channel_mac_accumulator #(
        .NWBITS(16), .NINBITS(26), .NCH(2), .NTERMS(4), .COUNT_BITS(2),
        .OUT_SHIFT(4), .OUT_BITS(16), .RELU_EN(1)
    ) dut_b (
        .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .weight(weight), .bias(bias), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
    );

    // C: shift 4, no ReLU
    multi_channel_mac_accumulator #(
        .NWBITS(16), .NINBITS(26), .NCH(2), .NTERMS(4), .COUNT_BITS(2),
        .OUT_SHIFT(4), .OUT_BITS(16), .RELU_EN(0)
    ) dut_c (
        .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .weight(weight), .bias(bias), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack2(input int l0, input int l1);
        logic [31:0] a;
        logic [31:0] b;
        a = l0;
        b = l1;
        return {b[15:0], a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sum and feed 4 beats; optional stall between beats 2 and 3. Ends in HOLD.
    task automatic run_sum(input int d, input int w0, input int w1, input int b0, input int b1,
                           input int stall);
        in_data = 26'(d);
        weight  = pack2(w0, w1);
        bias    = pack2(b0, b1);
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_val("in_ready_accum", 32'(in_ready_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && stall > 0) begin
                in_valid = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check_val("stall_in_ready", 32'(in_ready_a), 32'd1);
                    check_val("stall_out_valid", 32'(out_valid_a), 32'd0);
                end
            end
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_val("bias_cycle_out_valid", 32'(out_valid_a), 32'd0);
        check_val("bias_cycle_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        check_val("out_valid_t2", 32'(out_valid_a), 32'd1);
        check_val("busy_hold", 32'(busy_a), 32'd1);
    endtask

    // Consumer handshake, with a start pulse that HOLD must ignore.
    task automatic accept();
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check_val("accept_out_valid", 32'(out_valid_a), 32'd0);
        check_val("accept_busy", 32'(busy_a), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_b   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 26'd0;
        weight    = 32'd0;
        bias      = 32'd0;
        out_ready = 1'b0;

        #12;
        check_val("rst_out_valid", 32'(out_valid_a), 32'd0);
        check_val("rst_out_data", out_data_a, 32'd0);
        check_val("rst_in_ready", 32'(in_ready_a), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        reset_b = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("idle_ignores_valid", 32'(busy_a), 32'd0);

        // 1: basic sum
        run_sum(3, 2, -1, 1, 1, 0);
        check_val("t1_a", out_data_a, pack2(25, -11));
        check_val("t1_b", out_data_b, pack2(1, 0));
        check_val("t1_c", out_data_c, pack2(1, -1));
        accept();

        // 2: stalled input
        run_sum(3, 2, -1, 1, 1, 3);
        check_val("t2_a", out_data_a, pack2(25, -11));
        accept();

        // 3: saturation both ways
        run_sum(10000, 1, -1, 0, 0, 0);
        check_val("t3_sat_a", out_data_a, pack2(32767, -32768));
        check_val("t3_b", out_data_b, pack2(2500, 0));
        check_val("t3_c", out_data_c, pack2(2500, -2500));
        accept();

        // 3/4: ReLU and arithmetic floor shift, then a long hold with stray starts
        run_sum(-12, 1, 1, -2, 15, 0);
        check_val("t4_a", out_data_a, pack2(-50, -33));
        check_val("t4_relu_b", out_data_b, pack2(0, 0));
        check_val("t4_floor_c", out_data_c, pack2(-4, -3));
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            check_val("hold_valid", 32'(out_valid_c), 32'd1);
            check_val("hold_data", out_data_c, pack2(-4, -3));
        end
        start = 1'b0;
        accept();

        // 5: abort after two beats, then a clean run
        in_data = 26'd100;
        weight  = pack2(7, 7);
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", 32'(busy_a), 32'd0);
        check_val("abort_in_ready", 32'(in_ready_a), 32'd0);
        run_sum(3, 2, -1, 1, 1, 0);
        check_val("t5_clean", out_data_a, pack2(25, -11));

        // 6: asynchronous reset during HOLD
        #2;
        reset_b = 1'b0;
        #1;
        check_val("areset_out_valid", 32'(out_valid_a), 32'd0);
        check_val("areset_out_data", out_data_a, 32'd0);
        check_val("areset_busy", 32'(busy_a), 32'd0);
        #3;
        reset_b = 1'b1;
        tick();
        check_val("post_reset_busy", 32'(busy_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
